alu_ctrl_sequencer: RTL and testbench

ALU_CTRL_SEQUENCER -- requirements
Module: alu_ctrl_sequencer

---
 rtl/alu_ctrl_sequencer_pkg.sv | 41 ++++
 rtl/alu_ctrl_sequencer_if.sv | 54 +++++
 rtl/alu_ctrl_sequencer_reg_sel_decoder.sv | 21 ++
 rtl/alu_ctrl_sequencer.sv | 174 +++++++++++++++++
 tb/tb_alu_ctrl_sequencer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_sequencer_pkg.sv
// Shared types for the ALU control sequencer: FSM state encoding, opcode
// class boundaries and the opcode class decode.
package alu_ctrl_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StT0,
        StT1,
        StT2,
        StT3,
        StT4,
        StT5,
        StT6
    } state_e;

    typedef enum logic [1:0] {
        ClsIllegal,
        ClsR3,
        ClsImm,
        ClsHilo
    } opc_class_e;

    localparam int unsigned OpcR3Lo  = 32'h03;
    localparam int unsigned OpcR3Hi  = 32'h0B;
    localparam int unsigned OpcImmLo = 32'h0C;
    localparam int unsigned OpcImmHi = 32'h0E;
    localparam int unsigned OpcMul   = 32'h0F;
    localparam int unsigned OpcDiv   = 32'h10;

    function automatic opc_class_e opc_class(input int unsigned opc);
        if (opc >= OpcR3Lo && opc <= OpcR3Hi) begin
            return ClsR3;
        end else if (opc >= OpcImmLo && opc <= OpcImmHi) begin
            return ClsImm;
        end else if (opc == OpcMul || opc == OpcDiv) begin
            return ClsHilo;
        end
        return ClsIllegal;
    endfunction

endpackage

// File: rtl/alu_ctrl_sequencer_if.sv
// Control bundle between the sequencer and the datapath it steers.
//   start/mem_ack/ir : requests and status coming from the datapath side
//   *_in/*_out/...   : single-bit datapath strobes
//   reg_in/reg_out   : one-hot register load / bus-drive selects
//   alu_op           : ALU operation, non-zero only while the ALU computes
//   busy/done/err    : sequencer status
// master = sequencer, slave = datapath / stimulus side.
interface alu_ctrl_sequencer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 16,
    parameter int unsigned OPC_W  = 5
);
    logic              start;
    logic              mem_ack;
    logic [DATA_W-1:0] ir;

    logic              pc_out;
    logic              mar_in;
    logic              inc_pc;
    logic              zlo_in;
    logic              zlo_out;
    logic              zhi_in;
    logic              zhi_out;
    logic              pc_in;
    logic              mdr_read;
    logic              mdr_in;
    logic              mdr_out;
    logic              ir_in;
    logic              y_in;
    logic              c_out;
    logic              hi_in;
    logic              lo_in;
    logic [NREG-1:0]   reg_in;
    logic [NREG-1:0]   reg_out;
    logic [OPC_W-1:0]  alu_op;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  start, mem_ack, ir,
        output pc_out, mar_in, inc_pc, zlo_in, zlo_out, zhi_in, zhi_out, pc_in,
               mdr_read, mdr_in, mdr_out, ir_in, y_in, c_out, hi_in, lo_in,
               reg_in, reg_out, alu_op, busy, done, err
    );

    modport slave (
        output start, mem_ack, ir,
        input  pc_out, mar_in, inc_pc, zlo_in, zlo_out, zhi_in, zhi_out, pc_in,
               mdr_read, mdr_in, mdr_out, ir_in, y_in, c_out, hi_in, lo_in,
               reg_in, reg_out, alu_op, busy, done, err
    );

endinterface

// File: rtl/alu_ctrl_sequencer_reg_sel_decoder.sv
// Register select decoder: turns a register index into a one-hot select.
//   idx_i    : register index (log2(NREG) bits)
//   en_i     : when low the output is all zeros
//   onehot_o : NREG-bit one-hot select
module alu_ctrl_sequencer_reg_sel_decoder #(
    parameter int unsigned NREG = 16,
    localparam int unsigned RW  = $clog2(NREG)
) (
    input  logic [RW-1:0]   idx_i,
    input  logic            en_i,
    output logic [NREG-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// Microcoded-style control sequencer for a single-bus ALU datapath. One start
// request fetches an instruction (T0..T2) and executes it (T3..T6); all
// strobes are decoded from the state register and the latched instruction.
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high; returns to idle with all outputs low
//   seq_io : control bundle (master side), see alu_ctrl_sequencer_if
module alu_ctrl_sequencer
    import alu_ctrl_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 16,
    parameter int unsigned OPC_W  = 5
) (
    input logic                  clk,
    input logic                  reset,
    alu_ctrl_sequencer_if.master seq_io
);

    localparam int unsigned RW     = $clog2(NREG);
    localparam int unsigned OpcLsb = DATA_W - OPC_W;
    localparam int unsigned RaLsb  = OpcLsb - RW;
    localparam int unsigned RbLsb  = RaLsb - RW;
    localparam int unsigned RcLsb  = RbLsb - RW;

    state_e           state_q, state_d;
    logic [OPC_W-1:0] opc_q;
    logic [RW-1:0]    ra_q, rb_q, rc_q;

    opc_class_e       cls_ir;
    opc_class_e       cls_q;
    logic             reg_in_en;
    logic             reg_out_en;
    logic [RW-1:0]    reg_out_idx;

    // T2 must decide legality before the instruction is latched, so it looks
    // at the incoming ir; later states use the latched copy.
    assign cls_ir = opc_class(32'(seq_io.ir[OpcLsb +: OPC_W]));
    assign cls_q  = opc_class(32'(opc_q));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            opc_q   <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StT2) begin
                opc_q <= seq_io.ir[OpcLsb +: OPC_W];
                ra_q  <= seq_io.ir[RaLsb +: RW];
                rb_q  <= seq_io.ir[RbLsb +: RW];
                rc_q  <= seq_io.ir[RcLsb +: RW];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        seq_io.pc_out   = 1'b0;
        seq_io.mar_in   = 1'b0;
        seq_io.inc_pc   = 1'b0;
        seq_io.zlo_in   = 1'b0;
        seq_io.zlo_out  = 1'b0;
        seq_io.zhi_in   = 1'b0;
        seq_io.zhi_out  = 1'b0;
        seq_io.pc_in    = 1'b0;
        seq_io.mdr_read = 1'b0;
        seq_io.mdr_in   = 1'b0;
        seq_io.mdr_out  = 1'b0;
        seq_io.ir_in    = 1'b0;
        seq_io.y_in     = 1'b0;
        seq_io.c_out    = 1'b0;
        seq_io.hi_in    = 1'b0;
        seq_io.lo_in    = 1'b0;
        seq_io.alu_op   = '0;
        seq_io.done     = 1'b0;
        seq_io.err      = 1'b0;
        reg_in_en       = 1'b0;
        reg_out_en      = 1'b0;
        reg_out_idx     = rb_q;

        unique case (state_q)
            StIdle: begin
                if (seq_io.start) begin
                    state_d = StT0;
                end
            end
            StT0: begin
                seq_io.pc_out = 1'b1;
                seq_io.mar_in = 1'b1;
                seq_io.inc_pc = 1'b1;
                seq_io.zlo_in = 1'b1;
                state_d       = StT1;
            end
            StT1: begin
                // Z -> PC is repeated every wait cycle; the value is stable.
                seq_io.mdr_read = 1'b1;
                seq_io.mdr_in   = 1'b1;
                seq_io.zlo_out  = 1'b1;
                seq_io.pc_in    = 1'b1;
                if (seq_io.mem_ack) begin
                    state_d = StT2;
                end
            end
            StT2: begin
                seq_io.mdr_out = 1'b1;
                seq_io.ir_in   = 1'b1;
                if (cls_ir == ClsIllegal) begin
                    seq_io.done = 1'b1;
                    seq_io.err  = 1'b1;
                    state_d     = StIdle;
                end else begin
                    state_d = StT3;
                end
            end
            StT3: begin
                reg_out_en  = 1'b1;
                reg_out_idx = rb_q;
                seq_io.y_in = 1'b1;
                state_d     = StT4;
            end
            StT4: begin
                seq_io.zlo_in = 1'b1;
                seq_io.alu_op = opc_q;
                if (cls_q == ClsImm) begin
                    seq_io.c_out = 1'b1;
                end else begin
                    reg_out_en  = 1'b1;
                    reg_out_idx = rc_q;
                end
                seq_io.zhi_in = (cls_q == ClsHilo);
                state_d       = StT5;
            end
            StT5: begin
                seq_io.zlo_out = 1'b1;
                if (cls_q == ClsHilo) begin
                    seq_io.lo_in = 1'b1;
                    state_d      = StT6;
                end else begin
                    reg_in_en   = 1'b1;
                    seq_io.done = 1'b1;
                    state_d     = StIdle;
                end
            end
            StT6: begin
                seq_io.zhi_out = 1'b1;
                seq_io.hi_in   = 1'b1;
                seq_io.done    = 1'b1;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign seq_io.busy = (state_q != StIdle);

    alu_ctrl_sequencer_reg_sel_decoder #(
        .NREG(NREG)
    ) u_reg_in_dec (
        .idx_i   (ra_q),
        .en_i    (reg_in_en),
        .onehot_o(seq_io.reg_in)
    );

    alu_ctrl_sequencer_reg_sel_decoder #(
        .NREG(NREG)
    ) u_reg_out_dec (
        .idx_i   (reg_out_idx),
        .en_i    (reg_out_en),
        .onehot_o(seq_io.reg_out)
    );

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Scoreboard bench for alu_ctrl_sequencer: the driver pushes the expected
// per-instruction summary, the monitor builds the observed summary from the
// strobes and compares it when done is seen.
module tb_alu_ctrl_sequencer;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREG   = 16;
    localparam int unsigned OPC_W  = 5;

    typedef struct {
        int err;
        int lat;
        int t1;
        int y_sel;
        int t4_sel;
        int c_out;
        int alu_op;
        int zhi;
        int wr;
        int lo;
        int hi;
    } rec_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   cyc;
    rec_t exp_q[$];

    alu_ctrl_sequencer_if #(.DATA_W(DATA_W), .NREG(NREG), .OPC_W(OPC_W)) bus ();

    alu_ctrl_sequencer #(
        .DATA_W(DATA_W),
        .NREG  (NREG),
        .OPC_W (OPC_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .seq_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic void chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endfunction

    function automatic logic any_out();
        return bus.pc_out | bus.mar_in | bus.inc_pc | bus.zlo_in | bus.zlo_out |
               bus.zhi_in | bus.zhi_out | bus.pc_in | bus.mdr_read | bus.mdr_in |
               bus.mdr_out | bus.ir_in | bus.y_in | bus.c_out | bus.hi_in | bus.lo_in |
               (|bus.reg_in) | (|bus.reg_out) | (|bus.alu_op) | bus.busy | bus.done |
               bus.err;
    endfunction

    // Reference model: what one instruction must look like from outside.
    function automatic rec_t model(input logic [31:0] ir, input int waits);
        rec_t r;
        int op, ra, rb, rc;
        bit r3, imm, hilo;
        op   = int'((ir >> 27) & 32'h1f);
        ra   = int'((ir >> 23) & 32'hf);
        rb   = int'((ir >> 19) & 32'hf);
        rc   = int'((ir >> 15) & 32'hf);
        r3   = (op >= 3 && op <= 11);
        imm  = (op >= 12 && op <= 14);
        hilo = (op == 15 || op == 16);
        r = '{default: 0};
        r.t1 = 1 + waits;
        if (!(r3 || imm || hilo)) begin
            r.err = 1;
            r.lat = 3 + waits;
        end else begin
            r.lat    = 6 + waits + (hilo ? 1 : 0);
            r.y_sel  = 1 << rb;
            r.t4_sel = imm ? 0 : (1 << rc);
            r.c_out  = imm ? 1 : 0;
            r.alu_op = op;
            r.zhi    = hilo ? 1 : 0;
            r.wr     = hilo ? 0 : (1 << ra);
            r.lo     = hilo ? 1 : 0;
            r.hi     = hilo ? 1 : 0;
        end
        return r;
    endfunction

    // Monitor
    initial begin
        rec_t obs, e;
        bit   active, prev_done, t4;
        int   start_cnt, nd;
        active    = 0;
        prev_done = 0;
        start_cnt = 0;
        obs       = '{default: 0};
        forever begin
            @(negedge clk);
            if (reset) begin
                active    = 0;
                prev_done = 0;
            end else begin
                if (prev_done) chk("idle_after_done", int'(bus.busy), 0);
                prev_done = bus.done;
                if (bus.busy) begin
                    if (!active) begin
                        active    = 1;
                        obs       = '{default: 0};
                        start_cnt = cyc;
                    end
                    nd = int'(bus.pc_out) + int'(bus.zlo_out) + int'(bus.zhi_out) +
                         int'(bus.mdr_out) + int'(bus.c_out) + $countones(bus.reg_out);
                    chk("bus_drivers_le1", int'(nd > 1), 0);
                    t4 = bus.zlo_in && !bus.pc_out;
                    if (bus.y_in) obs.y_sel = int'(bus.reg_out);
                    if (t4) begin
                        obs.t4_sel = int'(bus.reg_out);
                        obs.c_out  = int'(bus.c_out);
                        obs.alu_op = int'(bus.alu_op);
                        obs.zhi    = int'(bus.zhi_in);
                    end else begin
                        chk("alu_op_outside_t4", int'(bus.alu_op), 0);
                    end
                    obs.wr = obs.wr | int'(bus.reg_in);
                    obs.lo += int'(bus.lo_in);
                    obs.hi += int'(bus.hi_in);
                    obs.t1 += int'(bus.pc_in);
                    if (bus.done) begin
                        obs.err = int'(bus.err);
                        obs.lat = cyc - start_cnt + 1;
                        active  = 0;
                        chk("expected_pending", int'(exp_q.size() > 0), 1);
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            chk("err", obs.err, e.err);
                            chk("latency", obs.lat, e.lat);
                            chk("t1_cycles", obs.t1, e.t1);
                            chk("t3_reg_out", obs.y_sel, e.y_sel);
                            chk("t4_reg_out", obs.t4_sel, e.t4_sel);
                            chk("t4_c_out", obs.c_out, e.c_out);
                            chk("t4_alu_op", obs.alu_op, e.alu_op);
                            chk("t4_zhi_in", obs.zhi, e.zhi);
                            chk("reg_in", obs.wr, e.wr);
                            chk("lo_in", obs.lo, e.lo);
                            chk("hi_in", obs.hi, e.hi);
                        end
                    end
                end else begin
                    active = 0;
                    chk("idle_outputs", int'(any_out()), 0);
                end
            end
        end
    end

    task automatic run(input logic [31:0] ir, input int waits, input bit hold);
        int n;
        exp_q.push_back(model(ir, waits));
        @(posedge clk);
        #1;
        bus.ir      = ir;
        bus.start   = 1'b1;
        bus.mem_ack = 1'b0;
        @(posedge clk);
        #1;
        bus.start = hold;
        repeat (1 + waits) @(posedge clk);
        #1;
        bus.mem_ack = 1'b1;
        n = 0;
        while (!bus.done && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", int'(bus.done), 1);
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.mem_ack = 1'b0;
    endtask

    task automatic reset_mid_t4(input logic [31:0] ir);
        int n;
        @(posedge clk);
        #1;
        bus.ir    = ir;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.mem_ack = 1'b1;
        n = 0;
        while (!(bus.busy && bus.zlo_in && !bus.pc_out) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reach_t4", int'(bus.zlo_in && !bus.pc_out), 1);
        #1;
        reset = 1'b1;
        #1;
        chk("reset_mid_outputs", int'(any_out()), 0);
        chk("reset_mid_busy", int'(bus.busy), 0);
        bus.mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("no_start_after_reset", int'(bus.busy), 0);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.mem_ack = 1'b0;
        bus.ir      = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", int'(any_out()), 0);
        chk("reset_busy", int'(bus.busy), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_without_start", int'(bus.busy), 0);
        end

        run(32'h2891_8000, 0, 1'b0);
        run(32'h2891_8000, 3, 1'b0);
        run({5'b01111, 4'd1, 4'd4, 4'd5, 15'd0}, 0, 1'b0);
        run({5'b01100, 4'd7, 4'd2, 4'd9, 15'd0}, 1, 1'b0);
        run({5'b11111, 27'd0}, 0, 1'b0);
        run({5'b10000, 4'd15, 4'd0, 4'd14, 15'd0}, 2, 1'b1);
        run({5'b00011, 4'd0, 4'd15, 4'd0, 15'd0}, 0, 1'b1);
        run({5'b00000, 4'd3, 4'd3, 4'd3, 15'd0}, 1, 1'b1);
        reset_mid_t4({5'b01111, 4'd2, 4'd4, 4'd5, 15'd0});
        run(32'h2891_8000, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run($urandom, int'($urandom_range(0, 3)), 1'(($urandom_range(0, 1))));
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
